// File: rtl/serial_master_port_if.sv
// Host, arbiter and slave-side signals of the serial bus master port.
interface serial_master_port_if #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned BURST_W = 12,
  parameter int unsigned SLAVE_W = 2
);
  // host side
  logic               start;
  logic [1:0]         instruction;
  logic [SLAVE_W-1:0] slave_select;
  logic [ADDR_W-1:0]  address;
  logic [BURST_W-1:0] burst_num;
  logic [DATA_W-1:0]  wdata;
  logic               wdata_valid;
  logic               wdata_ready;
  logic [DATA_W-1:0]  rdata;
  logic               rdata_valid;
  logic               host_busy;
  logic               done;
  logic               error;
  // arbiter side
  logic               approval_request;
  logic               approval_grant;
  logic               busy;
  // serial slave side
  logic               tx_slave_select;
  logic               tx_address;
  logic               tx_burst_number;
  logic               tx_data;
  logic               master_valid;
  logic               master_ready;
  logic               write_en;
  logic               read_en;
  logic               slave_ready;
  logic               slave_valid;
  logic               rx_data;
  logic               tx_done;

  modport master (
    input  start, instruction, slave_select, address, burst_num, wdata, wdata_valid,
           approval_grant, busy, slave_ready, slave_valid, rx_data,
    output wdata_ready, rdata, rdata_valid, host_busy, done, error, approval_request,
           tx_slave_select, tx_address, tx_burst_number, tx_data, master_valid,
           master_ready, write_en, read_en, tx_done
  );

  modport slave (
    output start, instruction, slave_select, address, burst_num, wdata, wdata_valid,
           approval_grant, busy, slave_ready, slave_valid, rx_data,
    input  wdata_ready, rdata, rdata_valid, host_busy, done, error, approval_request,
           tx_slave_select, tx_address, tx_burst_number, tx_data, master_valid,
           master_ready, write_en, read_en, tx_done
  );
endinterface

// File: rtl/serial_master_port.sv
// Serial bus master port: request/grant, serial header, multi-word burst transfer.
module serial_master_port #(
  parameter int unsigned ADDR_W        = 12,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned BURST_W       = 12,
  parameter int unsigned SLAVE_W       = 2,
  parameter int unsigned GRANT_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_master_port_if.master bus
);
  localparam int unsigned HL_AB  = (ADDR_W > BURST_W) ? ADDR_W : BURST_W;
  localparam int unsigned HL     = (HL_AB > SLAVE_W) ? HL_AB : SLAVE_W;
  localparam int unsigned HCNT_W = $clog2(HL + 1);
  localparam int unsigned BCNT_W = $clog2(DATA_W + 1);
  localparam int unsigned TCNT_W = $clog2(GRANT_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_BUS = 3'd2,
    HDR      = 3'd3,
    WR_WAIT  = 3'd4,
    WR_SHIFT = 3'd5,
    RD       = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t             state;
  logic               is_write;
  logic               hdr_seen;
  logic [SLAVE_W-1:0] sel_sr;
  logic [ADDR_W-1:0]  addr_sr;
  logic [BURST_W-1:0] burst_sr;
  logic [BURST_W-1:0] words;
  logic [TCNT_W-1:0]  wait_cnt;
  logic [HCNT_W-1:0]  hdr_cnt;
  logic [BCNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0]  wr_sr;
  logic [DATA_W-2:0]  rd_sr;

  logic               approval_request_q, master_valid_q, master_ready_q;
  logic               write_en_q, read_en_q, tx_done_q, done_q, error_q, host_busy_q;
  logic               tx_sel_q, tx_addr_q, tx_burst_q, tx_data_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               rdata_valid_q;

  logic bus_phase_c, grant_lost_c, timeout_c, last_word_c;
  logic wr_last_c, rd_word_c, finish_c, wdata_ready_c, wdata_accept_c;

  // Completion and abort conditions decoded from the current state.
  always_comb begin
    bus_phase_c    = (state == WAIT_BUS) || (state == HDR) || (state == WR_WAIT) ||
                     (state == WR_SHIFT) || (state == RD);
    grant_lost_c   = bus_phase_c && !bus.approval_grant;
    timeout_c      = (state == REQ) && !bus.approval_grant &&
                     (wait_cnt == TCNT_W'(GRANT_TIMEOUT - 1));
    last_word_c    = (words == BURST_W'(1));
    wr_last_c      = (state == WR_SHIFT) && (bit_cnt == BCNT_W'(DATA_W)) && last_word_c;
    rd_word_c      = (state == RD) && bus.slave_valid && (bit_cnt == BCNT_W'(DATA_W - 1));
    finish_c       = grant_lost_c || timeout_c || wr_last_c || (rd_word_c && last_word_c);
    wdata_ready_c  = (state == WR_WAIT) && bus.slave_ready;
    wdata_accept_c = wdata_ready_c && bus.wdata_valid;
  end

  // Transaction FSM with registered outputs; the finish block overrides the case.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      is_write           <= 1'b0;
      hdr_seen           <= 1'b0;
      sel_sr             <= '0;
      addr_sr            <= '0;
      burst_sr           <= '0;
      words              <= '0;
      wait_cnt           <= '0;
      hdr_cnt            <= '0;
      bit_cnt            <= '0;
      wr_sr              <= '0;
      rd_sr              <= '0;
      approval_request_q <= 1'b0;
      master_valid_q     <= 1'b0;
      master_ready_q     <= 1'b0;
      write_en_q         <= 1'b0;
      read_en_q          <= 1'b0;
      tx_done_q          <= 1'b0;
      done_q             <= 1'b0;
      error_q            <= 1'b0;
      host_busy_q        <= 1'b0;
      tx_sel_q           <= 1'b0;
      tx_addr_q          <= 1'b0;
      tx_burst_q         <= 1'b0;
      tx_data_q          <= 1'b0;
      rdata_q            <= '0;
      rdata_valid_q      <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      tx_done_q      <= 1'b0;
      rdata_valid_q  <= 1'b0;
      master_valid_q <= 1'b0;
      tx_sel_q       <= 1'b0;
      tx_addr_q      <= 1'b0;
      tx_burst_q     <= 1'b0;
      tx_data_q      <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start && (bus.instruction == 2'b01 || bus.instruction == 2'b10)) begin
            is_write           <= (bus.instruction == 2'b10);
            sel_sr             <= bus.slave_select;
            addr_sr            <= bus.address;
            burst_sr           <= bus.burst_num;
            words              <= (bus.burst_num == '0) ? BURST_W'(1) : bus.burst_num;
            wait_cnt           <= '0;
            hdr_seen           <= 1'b0;
            error_q            <= 1'b0;
            approval_request_q <= 1'b1;
            host_busy_q        <= 1'b1;
            state              <= REQ;
          end
        end
        REQ: begin
          if (bus.approval_grant) state <= WAIT_BUS;
          else                    wait_cnt <= wait_cnt + TCNT_W'(1);
        end
        WAIT_BUS: begin
          if (!bus.busy) begin
            state          <= HDR;
            hdr_seen       <= 1'b1;
            hdr_cnt        <= HCNT_W'(1);
            master_valid_q <= 1'b1;
            write_en_q     <= is_write;
            read_en_q      <= !is_write;
            tx_sel_q       <= sel_sr[0];
            tx_addr_q      <= addr_sr[0];
            tx_burst_q     <= burst_sr[0];
            sel_sr         <= sel_sr >> 1;
            addr_sr        <= addr_sr >> 1;
            burst_sr       <= burst_sr >> 1;
          end
        end
        HDR: begin
          if (hdr_cnt == HCNT_W'(HL)) begin
            bit_cnt <= '0;
            if (is_write) begin
              state <= WR_WAIT;
            end else begin
              state          <= RD;
              master_ready_q <= 1'b1;
            end
          end else begin
            master_valid_q <= 1'b1;
            tx_sel_q       <= sel_sr[0];
            tx_addr_q      <= addr_sr[0];
            tx_burst_q     <= burst_sr[0];
            sel_sr         <= sel_sr >> 1;
            addr_sr        <= addr_sr >> 1;
            burst_sr       <= burst_sr >> 1;
            hdr_cnt        <= hdr_cnt + HCNT_W'(1);
          end
        end
        WR_WAIT: begin
          if (wdata_accept_c) begin
            state          <= WR_SHIFT;
            master_valid_q <= 1'b1;
            tx_data_q      <= bus.wdata[0];
            wr_sr          <= bus.wdata >> 1;
            bit_cnt        <= BCNT_W'(1);
          end
        end
        WR_SHIFT: begin
          if (bit_cnt == BCNT_W'(DATA_W)) begin
            words <= words - BURST_W'(1);
            state <= WR_WAIT;
          end else begin
            master_valid_q <= 1'b1;
            tx_data_q      <= wr_sr[0];
            wr_sr          <= wr_sr >> 1;
            bit_cnt        <= bit_cnt + BCNT_W'(1);
          end
        end
        RD: begin
          if (bus.slave_valid) begin
            if (rd_word_c) begin
              rdata_q       <= {bus.rx_data, rd_sr};
              rdata_valid_q <= 1'b1;
              rd_sr         <= '0;
              bit_cnt       <= '0;
              words         <= words - BURST_W'(1);
            end else begin
              rd_sr   <= {bus.rx_data, rd_sr[DATA_W-2:1]};
              bit_cnt <= bit_cnt + BCNT_W'(1);
            end
          end
        end
        DONE: begin
          host_busy_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Enter DONE: release the bus, report status, drop any partial word.
      if (finish_c) begin
        state              <= DONE;
        done_q             <= 1'b1;
        error_q            <= grant_lost_c || timeout_c;
        tx_done_q          <= hdr_seen;
        approval_request_q <= 1'b0;
        master_ready_q     <= 1'b0;
        write_en_q         <= 1'b0;
        read_en_q          <= 1'b0;
        master_valid_q     <= 1'b0;
        tx_sel_q           <= 1'b0;
        tx_addr_q          <= 1'b0;
        tx_burst_q         <= 1'b0;
        tx_data_q          <= 1'b0;
        bit_cnt            <= '0;
        rd_sr              <= '0;
        if (grant_lost_c) rdata_valid_q <= 1'b0;
      end
    end
  end

  assign bus.wdata_ready      = wdata_ready_c;
  assign bus.rdata            = rdata_q;
  assign bus.rdata_valid      = rdata_valid_q;
  assign bus.host_busy        = host_busy_q;
  assign bus.done             = done_q;
  assign bus.error            = error_q;
  assign bus.approval_request = approval_request_q;
  assign bus.tx_slave_select  = tx_sel_q;
  assign bus.tx_address       = tx_addr_q;
  assign bus.tx_burst_number  = tx_burst_q;
  assign bus.tx_data          = tx_data_q;
  assign bus.master_valid     = master_valid_q;
  assign bus.master_ready     = master_ready_q;
  assign bus.write_en         = write_en_q;
  assign bus.read_en          = read_en_q;
  assign bus.tx_done          = tx_done_q;
endmodule

// File: tb/tb_serial_master_port.sv
// Directed testbench for serial_master_port.
module tb_serial_master_port;
  localparam int unsigned ADDR_W = 12, DATA_W = 8, BURST_W = 12, SLAVE_W = 2;
  localparam int unsigned GRANT_TIMEOUT = 16;
  localparam int HL = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serial_master_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
                          .SLAVE_W(SLAVE_W)) bus ();

  serial_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
                       .SLAVE_W(SLAVE_W), .GRANT_TIMEOUT(GRANT_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail = 0;

  // scenario knobs
  int grant_at, busy_low_at, grant_drop_at, sready_at, n_wr, rd_total;
  logic [7:0]  wr_words [2];
  logic [23:0] rd_stream;

  // captured results
  logic [11:0] cap_sel, cap_addr, cap_burst;
  logic [31:0] cap_data;
  int hdr_n, data_n, first_hdr, done_at, req_first, hdr_we, hdr_re;
  int wr_idx, rd_idx, ready_bad, mv_cnt;
  logic cap_err, cap_txd, err_c1;
  logic [7:0] rd_got [$];
  logic [22:0] all_out;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic snap_outputs();
    all_out = {bus.approval_request, bus.master_valid, bus.master_ready, bus.write_en,
               bus.read_en, bus.tx_slave_select, bus.tx_address, bus.tx_burst_number,
               bus.tx_data, bus.tx_done, bus.done, bus.error, bus.rdata_valid,
               bus.host_busy, bus.wdata_ready, bus.rdata};
  endtask

  task automatic set_req(input logic [1:0] instr, input logic [1:0] sel,
                         input logic [11:0] addr, input logic [11:0] burst);
    bus.instruction  = instr;
    bus.slave_select = sel;
    bus.address      = addr;
    bus.burst_num    = burst;
  endtask

  // Issues start at edge 0, then plays the bus environment and records activity.
  task automatic run_txn(input int limit);
    hdr_n = 0; data_n = 0; first_hdr = -1; done_at = -1; req_first = -1;
    hdr_we = 0; hdr_re = 0; wr_idx = 0; rd_idx = 0; ready_bad = 0; mv_cnt = 0;
    cap_sel = '0; cap_addr = '0; cap_burst = '0; cap_data = '0;
    cap_err = 1'b0; cap_txd = 1'b0; err_c1 = 1'b0;
    rd_got.delete();
    bus.approval_grant = 1'b0; bus.busy = 1'b1; bus.slave_ready = 1'b0;
    bus.wdata_valid = 1'b0; bus.wdata = '0; bus.slave_valid = 1'b0; bus.rx_data = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (c == 1) err_c1 = bus.error;
      if (bus.approval_request && req_first < 0) req_first = c;
      if (bus.master_valid) begin
        mv_cnt++;
        if (hdr_n < HL) begin
          if (hdr_n == 0) first_hdr = c;
          cap_sel[hdr_n]   = bus.tx_slave_select;
          cap_addr[hdr_n]  = bus.tx_address;
          cap_burst[hdr_n] = bus.tx_burst_number;
          if (bus.write_en) hdr_we++;
          if (bus.read_en) hdr_re++;
          hdr_n++;
        end else begin
          if (data_n < 32) cap_data[data_n] = bus.tx_data;
          data_n++;
        end
      end
      if (bus.rdata_valid) rd_got.push_back(bus.rdata);
      if (bus.done) begin
        done_at = c; cap_err = bus.error; cap_txd = bus.tx_done;
        break;
      end
      if (c == limit) break;
      bus.approval_grant = (grant_at >= 0 && c >= grant_at &&
                            (grant_drop_at < 0 || c < grant_drop_at));
      bus.busy        = (c < busy_low_at);
      bus.slave_ready = (c >= sready_at);
      bus.wdata_valid = (wr_idx < n_wr);
      bus.wdata       = wr_words[(wr_idx < 2) ? wr_idx : 1];
      bus.slave_valid = bus.master_ready && (c % 4 != 0) && (rd_idx < rd_total);
      bus.rx_data     = (rd_idx < rd_total) ? rd_stream[rd_idx] : 1'b0;
      #1;
      if (bus.wdata_ready && !bus.slave_ready) ready_bad++;
      if (bus.wdata_ready && bus.wdata_valid) wr_idx++;
      if (bus.slave_valid) rd_idx++;
      cyc();
    end
    bus.wdata_valid = 1'b0;
    bus.slave_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    snap_outputs();
    n_checks++;
    if (all_out !== '0) begin
      $display("FAIL reset_outputs: got %h expected 0", all_out); n_fail++;
    end
    @(negedge clk);
    reset = 1'b1;
    set_req(2'b11, 2'b01, 12'h001, 12'h001);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    n_checks++;
    if (bus.host_busy !== 1'b0 || bus.approval_request !== 1'b0) begin
      $display("FAIL ignored_instr: host_busy=%b req=%b expected 0 0",
               bus.host_busy, bus.approval_request); n_fail++;
    end
  endtask

  task automatic test_write();
    grant_at = 3; busy_low_at = 6; grant_drop_at = -1; sready_at = 0; rd_total = 0;
    n_wr = 2; wr_words[0] = 8'hFF; wr_words[1] = 8'h5A;
    set_req(2'b10, 2'b01, 12'hADD, 12'd2);
    run_txn(100);
    n_checks++;
    if (req_first !== 1) begin
      $display("FAIL wr_req_cycle: got %0d expected 1", req_first); n_fail++;
    end
    n_checks++;
    if (first_hdr !== 7) begin
      $display("FAIL wr_first_hdr: got %0d expected 7", first_hdr); n_fail++;
    end
    n_checks++;
    if (cap_addr !== 12'hADD) begin
      $display("FAIL wr_addr: got %h expected add", cap_addr); n_fail++;
    end
    n_checks++;
    if (cap_sel !== 12'h001 || cap_burst !== 12'h002) begin
      $display("FAIL wr_sel_burst: got %h %h expected 001 002", cap_sel, cap_burst); n_fail++;
    end
    n_checks++;
    if (hdr_we !== HL || hdr_re !== 0) begin
      $display("FAIL wr_hdr_en: we=%0d re=%0d expected 12 0", hdr_we, hdr_re); n_fail++;
    end
    n_checks++;
    if (data_n !== 16 || cap_data[15:0] !== 16'h5AFF) begin
      $display("FAIL wr_data: got %0d bits %h expected 16 bits 5aff", data_n, cap_data[15:0]);
      n_fail++;
    end
    n_checks++;
    if (done_at !== 37) begin
      $display("FAIL wr_done_cycle: got %0d expected 37", done_at); n_fail++;
    end
    n_checks++;
    if (cap_err !== 1'b0 || cap_txd !== 1'b1) begin
      $display("FAIL wr_status: error=%b tx_done=%b expected 0 1", cap_err, cap_txd); n_fail++;
    end
    cyc();
    n_checks++;
    if (bus.done !== 1'b0 || bus.host_busy !== 1'b0) begin
      $display("FAIL wr_done_pulse: done=%b host_busy=%b expected 0 0",
               bus.done, bus.host_busy); n_fail++;
    end
  endtask

  task automatic test_read();
    grant_at = 1; busy_low_at = 1; grant_drop_at = -1; sready_at = 0; n_wr = 0;
    rd_stream = {8'h01, 8'hA5, 8'h3C}; rd_total = 24;
    set_req(2'b01, 2'b10, 12'h123, 12'd3);
    run_txn(200);
    n_checks++;
    if (hdr_re !== HL || cap_addr !== 12'h123 || cap_burst !== 12'h003 || cap_sel !== 12'h002) begin
      $display("FAIL rd_header: re=%0d addr=%h burst=%h sel=%h expected 12 123 003 002",
               hdr_re, cap_addr, cap_burst, cap_sel); n_fail++;
    end
    n_checks++;
    if (rd_got.size() !== 3) begin
      $display("FAIL rd_count: got %0d words expected 3", rd_got.size()); n_fail++;
    end else if (rd_got[0] !== 8'h3C || rd_got[1] !== 8'hA5 || rd_got[2] !== 8'h01) begin
      $display("FAIL rd_words: got %h %h %h expected 3c a5 01", rd_got[0], rd_got[1], rd_got[2]);
      n_fail++;
    end
    n_checks++;
    if (done_at < 0 || cap_err !== 1'b0 || cap_txd !== 1'b1 || data_n !== 0) begin
      $display("FAIL rd_status: done_at=%0d error=%b tx_done=%b extra=%0d expected done 0 1 0",
               done_at, cap_err, cap_txd, data_n); n_fail++;
    end
    cyc();
  endtask

  task automatic test_timeout();
    grant_at = -1; busy_low_at = 0; grant_drop_at = -1; sready_at = 0; rd_total = 0;
    n_wr = 1; wr_words[0] = 8'h11;
    set_req(2'b10, 2'b00, 12'h010, 12'd1);
    run_txn(60);
    n_checks++;
    if (done_at !== 17) begin
      $display("FAIL to_done_cycle: got %0d expected 17", done_at); n_fail++;
    end
    n_checks++;
    if (cap_err !== 1'b1 || cap_txd !== 1'b0 || mv_cnt !== 0) begin
      $display("FAIL to_status: error=%b tx_done=%b mv=%0d expected 1 0 0",
               cap_err, cap_txd, mv_cnt); n_fail++;
    end
    cyc();
    cyc();
    n_checks++;
    if (bus.error !== 1'b1 || bus.host_busy !== 1'b0 || bus.approval_request !== 1'b0) begin
      $display("FAIL to_error_hold: error=%b host_busy=%b req=%b expected 1 0 0",
               bus.error, bus.host_busy, bus.approval_request); n_fail++;
    end
  endtask

  task automatic test_grant_drop();
    grant_at = 2; busy_low_at = 3; grant_drop_at = 20; sready_at = 0; rd_total = 0;
    n_wr = 1; wr_words[0] = 8'hC3;
    set_req(2'b10, 2'b11, 12'h0F0, 12'd1);
    run_txn(100);
    n_checks++;
    if (err_c1 !== 1'b0) begin
      $display("FAIL gd_error_clear: got %b expected 0", err_c1); n_fail++;
    end
    n_checks++;
    if (done_at !== 21) begin
      $display("FAIL gd_done_cycle: got %0d expected 21", done_at); n_fail++;
    end
    n_checks++;
    if (cap_err !== 1'b1 || cap_txd !== 1'b1) begin
      $display("FAIL gd_status: error=%b tx_done=%b expected 1 1", cap_err, cap_txd); n_fail++;
    end
    n_checks++;
    if (data_n !== 4 || cap_data[3:0] !== 4'h3) begin
      $display("FAIL gd_partial: got %0d bits %h expected 4 bits 3", data_n, cap_data[3:0]);
      n_fail++;
    end
    cyc();
    n_checks++;
    if (bus.host_busy !== 1'b0) begin
      $display("FAIL gd_idle: host_busy=%b expected 0", bus.host_busy); n_fail++;
    end
  endtask

  task automatic test_reset_mid_hdr();
    grant_at = 1; busy_low_at = 1; grant_drop_at = -1; sready_at = 0; rd_total = 0;
    n_wr = 1; wr_words[0] = 8'h3C;
    set_req(2'b10, 2'b01, 12'hFFF, 12'd1);
    run_txn(6);
    n_checks++;
    if (bus.master_valid !== 1'b1 || bus.write_en !== 1'b1) begin
      $display("FAIL rst_in_hdr: master_valid=%b write_en=%b expected 1 1",
               bus.master_valid, bus.write_en); n_fail++;
    end
    #2;
    reset = 1'b0;
    #1;
    snap_outputs();
    n_checks++;
    if (all_out !== '0) begin
      $display("FAIL rst_async: got %h expected 0", all_out); n_fail++;
    end
    cyc();
    cyc();
    n_checks++;
    if (bus.done !== 1'b0 || bus.host_busy !== 1'b0) begin
      $display("FAIL rst_no_done: done=%b host_busy=%b expected 0 0", bus.done, bus.host_busy);
      n_fail++;
    end
    @(negedge clk);
    reset = 1'b1;
    cyc();
    wr_words[0] = 8'h69;
    set_req(2'b10, 2'b10, 12'h456, 12'd1);
    run_txn(100);
    n_checks++;
    if (done_at < 0 || cap_err !== 1'b0 || data_n !== 8 || cap_data[7:0] !== 8'h69 ||
        cap_addr !== 12'h456) begin
      $display("FAIL rst_recover: done_at=%0d error=%b bits=%0d data=%h addr=%h expected done 0 8 69 456",
               done_at, cap_err, data_n, cap_data[7:0], cap_addr); n_fail++;
    end
    cyc();
  endtask

  task automatic test_burst_zero();
    grant_at = 1; busy_low_at = 1; grant_drop_at = -1; sready_at = 20; rd_total = 0;
    n_wr = 2; wr_words[0] = 8'h96; wr_words[1] = 8'h55;
    set_req(2'b10, 2'b00, 12'h321, 12'd0);
    run_txn(100);
    n_checks++;
    if (ready_bad !== 0) begin
      $display("FAIL bz_ready: wdata_ready high without slave_ready %0d times expected 0", ready_bad);
      n_fail++;
    end
    n_checks++;
    if (wr_idx !== 1 || data_n !== 8 || cap_data[7:0] !== 8'h96) begin
      $display("FAIL bz_one_word: words=%0d bits=%0d data=%h expected 1 8 96",
               wr_idx, data_n, cap_data[7:0]); n_fail++;
    end
    n_checks++;
    if (done_at !== 29 || cap_err !== 1'b0) begin
      $display("FAIL bz_done: done_at=%0d error=%b expected 29 0", done_at, cap_err); n_fail++;
    end
    cyc();
  endtask

  initial begin
    bus.start = 1'b0; bus.instruction = 2'b00; bus.slave_select = '0; bus.address = '0;
    bus.burst_num = '0; bus.wdata = '0; bus.wdata_valid = 1'b0; bus.approval_grant = 1'b0;
    bus.busy = 1'b1; bus.slave_ready = 1'b0; bus.slave_valid = 1'b0; bus.rx_data = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_grant_drop();
    test_reset_mid_hdr();
    test_burst_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
